// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, constants and small-sigma functions used by the
// message scheduler and the compression core.
package sha256_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int WORDS_PER_BLOCK = 16;
  localparam int SHA256_ROUNDS   = 64;

  function automatic word_t small_sigma0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/message_scheduler.sv
// SHA-256 message schedule: streams W0..W(NUM_ROUNDS-1) from a 16-word
// sliding window under a valid/ready handshake.
module message_scheduler
  import sha256_pkg::*;
#(
  parameter int NUM_ROUNDS = SHA256_ROUNDS  // legal range 16..64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] block_in,
  input  logic         load,
  input  logic         w_ready,
  output logic [31:0]  w_out,
  output logic         w_valid,
  output logic [5:0]   t_index,
  output logic         busy,
  output logic         done,
  output state_e       state_dbg_o
);

  // Handshake: a word transfers on a rising edge where w_valid && w_ready;
  // w_out and t_index hold steady while w_valid is high and w_ready is low.

  localparam logic [5:0] LAST_T = 6'(NUM_ROUNDS - 1);

  state_e     state_q, state_d;
  word_t      window_q [WORDS_PER_BLOCK];
  word_t      window_d [WORDS_PER_BLOCK];
  logic [5:0] t_q, t_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      for (int i = 0; i < WORDS_PER_BLOCK; i++) window_q[i] <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      for (int i = 0; i < WORDS_PER_BLOCK; i++) window_q[i] <= window_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    for (int i = 0; i < WORDS_PER_BLOCK; i++) window_d[i] = window_q[i];

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          for (int i = 0; i < WORDS_PER_BLOCK; i++)
            window_d[i] = block_in[511 - 32*i -: 32];
          t_d     = '0;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (w_ready) begin
          if (t_q == LAST_T) begin
            state_d = ST_DONE;
          end else begin
            // Recurrence runs on every shift; for t<16 it only fills slots
            // that are not emitted until t>=16, where it is exact.
            for (int i = 0; i < WORDS_PER_BLOCK - 1; i++) window_d[i] = window_q[i+1];
            window_d[WORDS_PER_BLOCK-1] = small_sigma1(window_q[14]) + window_q[9]
                                        + small_sigma0(window_q[1]) + window_q[0];
            t_d = t_q + 6'd1;
          end
        end
      end
      ST_DONE: begin
        t_d     = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    w_valid     = (state_q == ST_EMIT);
    w_out       = w_valid ? window_q[0] : '0;
    t_index     = w_valid ? t_q : '0;
    busy        = (state_q != ST_IDLE);
    done        = (state_q == ST_DONE);
    state_dbg_o = state_q;
  end

endmodule

// File: tb/tb_message_scheduler.sv
// Randomized bench for message_scheduler against a full-array SHA-256
// schedule model.
module tb_message_scheduler;
  import sha256_pkg::*;

  localparam int N = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] block_in;
  logic         load;
  logic         w_ready;
  logic [31:0]  w_out;
  logic         w_valid;
  logic [5:0]   t_index;
  logic         busy;
  logic         done;
  state_e       state_dbg;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q [$];
  logic [31:0] model_w [N];
  logic [31:0] got_w [N];

  message_scheduler #(.NUM_ROUNDS(N)) dut (
    .clk(clk), .rst(rst), .block_in(block_in), .load(load), .w_ready(w_ready),
    .w_out(w_out), .w_valid(w_valid), .t_index(t_index), .busy(busy),
    .done(done), .state_dbg_o(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Full 64-entry schedule, computed the textbook way
  task automatic build_model(input logic [511:0] blk);
    for (int t = 0; t < N; t++) begin
      if (t < 16) model_w[t] = blk[511 - 32*t -: 32];
      else model_w[t] = ref_s1(model_w[t-2]) + model_w[t-7]
                      + ref_s0(model_w[t-15]) + model_w[t-16];
    end
    exp_q.delete();
    for (int t = 0; t < N; t++) exp_q.push_back(model_w[t]);
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  // Load at the current negedge, stream all words, check DONE then IDLE.
  // Returns at the negedge of the first IDLE cycle, ready for a back-to-back load.
  task automatic run_block(input logic [511:0] blk, input bit rand_ready,
                           input int inject_at, input string tag);
    int idx, cycles;
    bit prev_stall;
    logic [31:0] prev_word;
    build_model(blk);
    block_in = blk;
    load = 1'b1;
    w_ready = 1'b0;
    @(negedge clk);
    load = 1'b0;
    idx = 0; cycles = 0; prev_stall = 1'b0; prev_word = '0;
    while (idx < N && cycles < 1000) begin
      total++;
      if (w_valid !== 1'b1) begin
        bad++; $display("FAIL %s w_valid t=%0d got=%b exp=1", tag, idx, w_valid);
      end
      total++;
      if (w_out !== exp_q[0]) begin
        bad++; $display("FAIL %s w_out t=%0d got=%h exp=%h", tag, idx, w_out, exp_q[0]);
      end
      total++;
      if (t_index !== 6'(idx)) begin
        bad++; $display("FAIL %s t_index got=%0d exp=%0d", tag, t_index, idx);
      end
      if (prev_stall) begin
        total++;
        if (w_out !== prev_word) begin
          bad++; $display("FAIL %s stall_stable got=%h exp=%h", tag, w_out, prev_word);
        end
      end
      if (cycles == inject_at) begin
        load = 1'b1;
        block_in = ~blk;
      end else begin
        load = 1'b0;
      end
      w_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      prev_word = w_out;
      @(negedge clk);
      if (w_ready) begin
        got_w[idx] = prev_word;
        void'(exp_q.pop_front());
        idx++;
        prev_stall = 1'b0;
      end else begin
        prev_stall = 1'b1;
      end
      cycles++;
    end
    load = 1'b0;
    w_ready = 1'b0;
    total++;
    if (idx != N) begin
      bad++; $display("FAIL %s timeout accepted=%0d exp=%0d", tag, idx, N);
    end
    total++;
    if ({done, w_valid, busy, t_index} !== {1'b1, 1'b0, 1'b1, 6'd0}) begin
      bad++; $display("FAIL %s done_cycle got done=%b valid=%b busy=%b t=%0d exp 1 0 1 0",
                      tag, done, w_valid, busy, t_index);
    end
    @(negedge clk);
    total++;
    if ({done, w_valid, busy} !== 3'b000) begin
      bad++; $display("FAIL %s after_done got done=%b valid=%b busy=%b exp 0 0 0",
                      tag, done, w_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; w_ready = 1'b0; block_in = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({w_out, w_valid, t_index, busy, done} !== '0) begin
      bad++; $display("FAIL reset outputs got w=%h v=%b t=%0d b=%b d=%b exp all 0",
                      w_out, w_valid, t_index, busy, done);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({w_valid, busy, done} !== 3'b000) begin
      bad++; $display("FAIL reset idle got v=%b b=%b d=%b exp 0 0 0", w_valid, busy, done);
    end
  endtask

  task automatic test_abc(input bit rand_ready, input string tag);
    logic [511:0] blk;
    blk = '0;
    blk[511:480] = 32'h61626380;
    blk[31:0]    = 32'h00000018;
    run_block(blk, rand_ready, -1, tag);
    total++;
    if (got_w[0] !== 32'h61626380 || got_w[15] !== 32'h00000018 ||
        got_w[16] !== 32'h61626380 || got_w[17] !== 32'h000F0000) begin
      bad++; $display("FAIL %s known_words got %h %h %h %h exp 61626380 00000018 61626380 000f0000",
                      tag, got_w[0], got_w[15], got_w[16], got_w[17]);
    end
  endtask

  task automatic test_zero();
    run_block('0, 1'b0, -1, "zero");
    for (int t = 0; t < N; t++) begin
      total++;
      if (got_w[t] !== 32'h0) begin
        bad++; $display("FAIL zero word t=%0d got=%h exp=0", t, got_w[t]);
      end
    end
  endtask

  task automatic test_load_during_emit();
    run_block(rand_block(), 1'b1, 10, "load_in_emit");
    run_block(rand_block(), 1'b0, 40, "load_in_emit2");
  endtask

  task automatic test_reset_mid();
    int n;
    block_in = rand_block();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    w_ready = 1'b1;
    n = 0;
    while (!(w_valid && t_index == 6'd20) && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 200) begin
      bad++; $display("FAIL reset_mid reach_t20 got t=%0d exp=20", t_index);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({w_valid, busy, done, t_index} !== 9'd0) begin
      bad++; $display("FAIL reset_mid after_rst got v=%b b=%b d=%b t=%0d exp 0 0 0 0",
                      w_valid, busy, done, t_index);
    end
    rst = 1'b0;
    w_ready = 1'b0;
    @(negedge clk);
    run_block(rand_block(), 1'b1, -1, "reset_mid_reload");
  endtask

  task automatic test_back_to_back();
    run_block(rand_block(), 1'b0, -1, "b2b_first");
    run_block(rand_block(), 1'b0, -1, "b2b_second");
    run_block(rand_block(), 1'b1, -1, "b2b_third");
  endtask

  initial begin
    test_reset();
    test_abc(1'b0, "abc");
    test_zero();
    test_abc(1'b1, "abc_rand_ready");
    test_load_during_emit();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/message_scheduler.md
Name: message_scheduler

Overview:
- SHA-256 message-schedule stage directly downstream of the preprocessor.
- Accepts one padded 512-bit block, selected by the controller from the preprocessor's two-block output using its position index.
- Streams the 64 schedule words W0..W63 to the compression core, one word per accepted transfer, under a valid/ready handshake.
- Uses a 16-word sliding window, so storage is 512 bits rather than 64 words.

Parameters:
- NUM_ROUNDS, 64, number of schedule words emitted per block; must be ≥16 and ≤64.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset; synchronous and active-high, sampled on the rising edge of clk.
- block_in  in  512  padded message block; block_in[511:480] is W0, block_in[31:0] is W15.
- load  in  1  start request; accepted only in IDLE.
- w_ready  in  1  consumer accepts w_out this cycle.
- w_out  out  32  current schedule word W[t].
- w_valid  out  1  w_out holds a valid word.
- t_index  out  6  index t of w_out.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - Window and counter are cleared to 0.
  - w_out, w_valid, t_index, busy and done are all 0.
  - Reset takes priority over every other input, including mid-block; the partial block is discarded.
- States: IDLE, EMIT, DONE.
- IDLE:
  - With load=1, block_in is captured into window[0..15] (window[0]=block_in[511:480]), t is set to 0, and the next state is EMIT.
  - Latency: w_valid is first high one cycle after the load edge.
- EMIT outputs:
  - w_valid=1, w_out=window[0], t_index=t.
- EMIT, w_ready=0:
  - All state holds; w_out must stay stable.
- EMIT, w_ready=1 and t<NUM_ROUNDS-1:
  - window[i] <= window[i+1] for i=0..14.
  - window[15] <= σ1(window[14]) + window[9] + σ0(window[1]) + window[0], mod 2^32.
  - t <= t+1.
- EMIT, w_ready=1 and t=NUM_ROUNDS-1:
  - Next state is DONE.
- Schedule functions:
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - Addition wraps at 32 bits; there is no carry out.
- Words 0..15 are the raw block words; the recurrence is applied on every shift and is naturally correct from t=16 on.
- DONE: done=1, w_valid=0, busy=1 for exactly one cycle, then IDLE.
- load outside IDLE is ignored; there is no queueing, and block_in is sampled only on an accepted load.
- Back-to-back blocks: earliest next load is the cycle after DONE. Minimum spacing with w_ready tied high is NUM_ROUNDS+2 cycles per block.
- t_index is 0 whenever w_valid=0.

Decomposition:
- Package sha256_pkg:
  - typedef word_t (logic [31:0]) and state enum.
  - Constants WORDS_PER_BLOCK=16 and SHA256_ROUNDS=64.
  - Functions small_sigma0 and small_sigma1, shared with the compression core (which adds big Σ functions).
- No sub-module needed: a single always_ff plus always_comb is sufficient.

Test Plan:
- "abc" padded block (0x61626380, 13×0x00000000, 0x00000018), w_ready=1:
  - W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000.
  - w_valid high for exactly 64 consecutive cycles, then done pulses once.
- All-zero block: all 64 words are 0x00000000, t_index runs 0..63 in order, done is a single-cycle pulse.
- "abc" block with w_ready toggled pseudo-randomly: same word sequence as the first test, w_out stable while w_ready=0, total accepted transfers = 64.
- load pulsed during EMIT with a different block_in: ignored, and the sequence continues unchanged from the first block.
- rst asserted at t=20: next cycle w_valid=0, busy=0, done=0. A new load then restarts from W0 of the new block.
- Two blocks loaded back-to-back (second load the cycle after DONE): second sequence starts correctly with no word mixing; verify against a reference model.
